// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks.
// Holds the default operand width and the one-hot sequencer state encoding.
package rsa_pkg;

   localparam int DEFAULT_W = 8;
   localparam int STATE_W   = 6;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 6'b000001,
      ST_CHECK = 6'b000010,
      ST_TEST  = 6'b000100,
      ST_MUL   = 6'b001000,
      ST_SQR   = 6'b010000,
      ST_DONE  = 6'b100000
   } state_e;

endpackage

// File: rtl/modexp_sequencer.sv
// Right-to-left square-and-multiply sequencer for base^exponent mod modulus.
// Every multiply is delegated to an external shared mulmod unit over mm_req/mm_ack.
module modexp_sequencer
   import rsa_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] base,
   input  logic [W-1:0] exponent,
   input  logic [W-1:0] modulus,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         err,
   output logic         mm_req,
   output logic [W-1:0] mm_a,
   output logic [W-1:0] mm_b,
   output logic [W-1:0] mm_n,
   input  logic         mm_ack,
   input  logic [W-1:0] mm_result
);

   state_e state_q, state_d;

   logic [W-1:0] b_q, e_q, n_q, acc_q;
   logic [W-1:0] mm_a_q, mm_b_q;
   logic [W-1:0] result_q;
   logic         err_q;
   logic         req_q;

   logic [W-1:0] e_half;
   logic         ack_ok;
   logic         capture, issue, load_acc, load_b, clear_e;
   logic         finish_ok, finish_err;

   assign e_half = e_q >> 1;
   // An ack only counts while our own request is outstanding.
   assign ack_ok = req_q & mm_ack;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every signal below gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      capture    = 1'b0;
      issue      = 1'b0;
      load_acc   = 1'b0;
      load_b     = 1'b0;
      clear_e    = 1'b0;
      finish_ok  = 1'b0;
      finish_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if ((n_q < W'(2)) || (b_q >= n_q)) begin
               finish_err = 1'b1;
               state_d    = ST_DONE;
            end else begin
               state_d = ST_TEST;
            end
         end
         ST_TEST: begin
            if (e_q == '0) begin
               finish_ok = 1'b1;
               state_d   = ST_DONE;
            end else if (e_q[0]) begin
               state_d = ST_MUL;
            end else begin
               state_d = ST_SQR;
            end
         end
         ST_MUL: begin
            if (ack_ok) begin
               load_acc = 1'b1;
               state_d  = ST_SQR;
            end else begin
               issue = ~req_q;
            end
         end
         ST_SQR: begin
            // The last squaring is never used, so it is skipped outright.
            if (e_half == '0) begin
               clear_e = 1'b1;
               state_d = ST_TEST;
            end else if (ack_ok) begin
               load_b  = 1'b1;
               state_d = ST_TEST;
            end else begin
               issue = ~req_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         b_q      <= '0;
         e_q      <= '0;
         n_q      <= '0;
         acc_q    <= '0;
         mm_a_q   <= '0;
         mm_b_q   <= '0;
         req_q    <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (capture) begin
            b_q   <= base;
            e_q   <= exponent;
            n_q   <= modulus;
            acc_q <= W'(1);
         end

         // Request is registered: it rises the cycle after entering MUL/SQR,
         // which also guarantees a low cycle right after every ack.
         if (issue) begin
            req_q  <= 1'b1;
            mm_a_q <= (state_q == ST_MUL) ? acc_q : b_q;
            mm_b_q <= b_q;
         end else if (ack_ok) begin
            req_q <= 1'b0;
         end

         if (load_acc) acc_q <= mm_result;

         if (load_b) begin
            b_q <= mm_result;
            e_q <= e_half;
         end else if (clear_e) begin
            e_q <= '0;
         end

         if (finish_err) begin
            result_q <= '0;
            err_q    <= 1'b1;
         end else if (finish_ok) begin
            result_q <= acc_q;
            err_q    <= 1'b0;
         end
      end
   end

   assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign err    = err_q;
   assign mm_req = req_q;
   assign mm_a   = mm_a_q;
   assign mm_b   = mm_b_q;
   assign mm_n   = n_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Self-checking bench for modexp_sequencer: mulmod responder with programmable
// ack delay, directed corner jobs and randomized jobs against an arithmetic model.
module tb_modexp_sequencer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] base, exponent, modulus;
   logic         busy, done, err, mm_req, mm_ack;
   logic [W-1:0] result, mm_a, mm_b, mm_n, mm_result;

   logic         resp_ack = 1'b0;
   logic [W-1:0] resp_val = '0;
   logic         stray_ack = 1'b0;
   logic [W-1:0] stray_val = '0;
   int           ack_delay = 0;
   int           txn_count = 0;
   int           vectors = 0;
   int           miscompares = 0;
   int           last_result = 0;

   assign mm_ack    = resp_ack | stray_ack;
   assign mm_result = stray_ack ? stray_val : resp_val;

   modexp_sequencer #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base      (base),
      .exponent  (exponent),
      .modulus   (modulus),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .err       (err),
      .mm_req    (mm_req),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_n      (mm_n),
      .mm_ack    (mm_ack),
      .mm_result (mm_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: plain repeated multiplication, transaction count from bit statistics.
   function automatic void ref_modexp(input int b, input int e, input int n,
                                      output int r, output bit er, output int txns);
      if (n < 2 || b >= n) begin
         r = 0; er = 1'b1; txns = 0;
         return;
      end
      er = 1'b0;
      r  = 1;
      for (int i = 0; i < e; i++) r = (r * b) % n;
      txns = (e == 0) ? 0 : $countones(e) + $clog2(e + 1) - 1;
   endfunction

   // Mulmod responder: acks ack_delay cycles after the request is first seen.
   always begin : responder
      bit           in_txn;
      int           wait_n;
      logic [W-1:0] cap_a, cap_b;
      @(posedge clk); #1;
      if (resp_ack) begin
         resp_ack = 1'b0;
         check("req_low_after_ack", mm_req, 0);
      end else if (mm_req) begin
         if (!in_txn) begin
            in_txn = 1'b1;
            wait_n = 0;
            cap_a  = mm_a;
            cap_b  = mm_b;
            txn_count++;
         end else begin
            check("hold_mm_a", mm_a, cap_a);
            check("hold_mm_b", mm_b, cap_b);
         end
         if (wait_n >= ack_delay) begin
            resp_val = (mm_n == 0) ? '0 : W'((int'(cap_a) * int'(cap_b)) % int'(mm_n));
            resp_ack = 1'b1;
            in_txn   = 1'b0;
         end else begin
            wait_n++;
         end
      end else begin
         in_txn = 1'b0;
      end
   end

   task automatic wait_done(input string tag, output int cyc);
      cyc = 0;
      while (!done && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_done_seen"}, done, 1);
   endtask

   // Caller is aligned at posedge+1; returns aligned the same way.
   task automatic run_job(input int b, input int e, input int n, input int dly,
                          input string tag, output int cyc);
      int r, t, t0;
      bit er;
      ref_modexp(b, e, n, r, er, t);
      ack_delay = dly;
      base = W'(b); exponent = W'(e); modulus = W'(n);
      start = 1'b1;
      t0 = txn_count;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy"}, busy, 1);
      wait_done(tag, cyc);
      check({tag, "_result"}, result, r);
      check({tag, "_err"}, err, er);
      check({tag, "_txns"}, txn_count - t0, t);
      last_result = r;
      @(posedge clk); #1;
      check({tag, "_done_single"}, done, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int cyc, bb, ee, nn, dd, dones, guard;
      reset = 1'b0; start = 1'b0;
      base = '0; exponent = '0; modulus = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_req", mm_req, 0);
      check("rst_err", err, 0);
      check("rst_result", result, 0);
      check("rst_mm_a", mm_a, 0);
      check("rst_mm_b", mm_b, 0);
      check("rst_mm_n", mm_n, 0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      run_job(4, 3, 33, 2, "j4e3", cyc);
      run_job(31, 7, 33, 1, "j31e7", cyc);
      run_job(7, 0, 33, 3, "e0", cyc);
      check("e0_latency", cyc + 1, 3);
      run_job(0, 5, 1, 0, "n1", cyc);
      check("n1_latency", cyc + 1, 2);
      run_job(40, 3, 33, 0, "b_ge_n", cyc);

      // Reset in the middle of an outstanding mulmod request.
      ack_delay = 5;
      base = 8'd31; exponent = 8'd7; modulus = 8'd33;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while (!mm_req && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("abort_req_seen", mm_req, 1);
      @(negedge clk); reset = 1'b0;
      #1;
      check("abort_req", mm_req, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      @(negedge clk); @(negedge clk); reset = 1'b1;
      dones = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      run_job(4, 3, 33, 2, "after_abort", cyc);

      // Stray ack while idle must not disturb anything.
      stray_val = 8'h55; stray_ack = 1'b1;
      @(posedge clk); #1;
      stray_ack = 1'b0;
      check("stray_done", done, 0);
      check("stray_busy", busy, 0);
      check("stray_req", mm_req, 0);
      check("stray_result", result, last_result);

      // start held high: one job per IDLE entry, operands captured at acceptance.
      ack_delay = 1;
      base = 8'd4; exponent = 8'd3; modulus = 8'd33;
      start = 1'b1;
      @(posedge clk); #1;
      check("held_busy_a", busy, 1);
      base = 8'd31; exponent = 8'd7;
      wait_done("held_a", cyc);
      check("held_result_a", result, 31);
      @(posedge clk); #1;
      check("held_idle_gap", busy, 0);
      @(posedge clk); #1;
      check("held_busy_b", busy, 1);
      start = 1'b0;
      wait_done("held_b", cyc);
      check("held_result_b", result, 4);
      dones = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("held_no_extra", dones, 0);

      for (int i = 0; i < 24; i++) begin
         nn = $urandom_range(0, 255);
         if ($urandom_range(0, 7) == 0 || nn == 0) bb = $urandom_range(0, 255);
         else bb = $urandom % nn;
         ee = $urandom_range(0, 255);
         dd = $urandom_range(0, 5);
         run_job(bb, ee, nn, dd, $sformatf("rnd%0d", i), cyc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/modexp_sequencer.md
MODEXP_SEQUENCER -- requirements
Module: modexp_sequencer

Interface
REQ-001 Parameter: W, default 8, operand/modulus width in bits.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  job request, sampled only in IDLE.
REQ-005 base  input  W  message/ciphertext operand, captured on accepted start.
REQ-006 exponent  input  W  exponent e or d, captured on accepted start.
REQ-007 modulus  input  W  RSA modulus n, captured on accepted start.
REQ-008 busy  output  1  high from the cycle after start acceptance until done.
REQ-009 done  output  1  one-cycle pulse when result/err are valid.
REQ-010 result  output  W  base^exponent mod modulus, held until next accepted start.
REQ-011 err  output  1  operand error flag, valid with done, held like result.
REQ-012 mm_req  output  1  request to the shared mulmod unit.
REQ-013 mm_a, mm_b  output  W each  mulmod operands.
REQ-014 mm_n  output  W  mulmod modulus, equal to the captured modulus.
REQ-015 mm_ack  input  1  mulmod completion, single-cycle pulse, meaningful only while mm_req is high.
REQ-016 mm_result  input  W  (mm_a*mm_b) mod mm_n, valid in the mm_ack cycle.

Function
REQ-017 States: IDLE, CHECK, TEST, MUL, SQR, DONE, encoded one-hot.
REQ-018 IDLE with start=1 captures base, exponent and modulus, sets acc=1, and moves to CHECK; start while not in IDLE is ignored.
REQ-019 CHECK: if modulus<2 or base>=modulus, set err=1 and result=0 and go to DONE; else go to TEST.
REQ-020 TEST: e==0 -> DONE; e[0]=1 -> MUL; otherwise -> SQR.
REQ-021 MUL: mm_req=1, mm_a=acc, mm_b=b; on mm_ack, acc<=mm_result and go to SQR.
REQ-022 SQR: if (e>>1)==0, e<=0 and go to TEST with no request issued; else mm_req=1, mm_a=mm_b=b, and on mm_ack b<=mm_result, e<=e>>1, go to TEST.
REQ-023 Handshake: mm_req and its operands stay stable from assertion until the mm_ack cycle, and mm_req is low in the cycle after mm_ack.
REQ-024 An mm_ack that arrives while mm_req is low is ignored.
REQ-025 DONE: result<=acc (or 0 when err=1), done=1 for exactly one cycle, then return to IDLE.
REQ-026 exponent=0 with a valid modulus gives result=1, err=0, and zero mulmod transactions.
REQ-027 The number of mulmod transactions equals popcount(e) plus (bit-length(e) minus 1).
REQ-028 Latency is unbounded only through mm_ack; there is no internal timeout.
REQ-029 All arithmetic is done in the mulmod unit; the sequencer holds only W-bit registers with no internal multiply.

Reset
REQ-030 reset low forces IDLE asynchronously, and drives busy, done, mm_req, err = 0; result, acc = 0; mm_a, mm_b, mm_n = 0.
REQ-031 Reset asserted mid-job aborts the job, mm_req falls without waiting for mm_ack, and no done pulse follows.
REQ-032 Release of reset takes effect on the first rising clk edge after reset goes high.

Structure
REQ-033 A shared package rsa_pkg holds the state one-hot encoding constants and the default W.
REQ-034 No sub-module: the mulmod unit is external, shared with other RSA datapath users, and connected through the mm_* port.

Verification
REQ-035 The bench provides a mulmod responder model with a programmable ack delay of 0-5 cycles.
REQ-036 n=33, base=4, e=3, delay 2 -> result=31, err=0, 3 transactions.
REQ-037 n=33, base=31, e=7 -> result=4, 5 transactions, single done pulse.
REQ-038 n=33, base=7, e=0 -> result=1, no mm_req, done 3 cycles after start.
REQ-039 n=1, base=0, e=5 -> err=1, result=0, no mm_req; separately, n=33, base=40 -> err=1.
REQ-040 Reset pulsed while mm_req=1 during n=33 e=7 -> mm_req=0 immediately, busy=0, no done; a following job n=33, base=4, e=3 -> 31.
REQ-041 start held high through a whole job, plus a spurious mm_ack in IDLE -> exactly one job per IDLE entry, and the stray ack has no effect.
